// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring algorithm, one quotient
// bit per cycle, result written straight to the register-file write port.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            w_enabled,
    output logic [4:0]      w_addr,
    output logic [XLEN-1:0] w_data,
    output logic [1:0]      dbg_state
);

    // Handshake: start is a request taken only on a rising edge where the unit is
    // IDLE and flush is low; busy is the inverse of ready and requests are never queued.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_nx;

    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [CW-1:0]   r_cnt;
    logic            r_op_rem;
    logic [4:0]      r_rd;
    logic            r_neg_q;
    logic            r_neg_r;

    logic            w_accept;
    logic            w_signed;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic            w_last;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic [XLEN-1:0] w_special_data;
    logic [XLEN:0]   w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quot_nx;
    logic [XLEN-1:0] w_q_res;
    logic [XLEN-1:0] w_r_res;

    logic            w_busy_nx;
    logic            w_wen_nx;
    logic [4:0]      w_addr_nx;
    logic [XLEN-1:0] w_data_nx;

    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_signed   = !op[0];
    assign w_div_zero = (rs2_val == '0);
    assign w_ovf      = w_signed && (rs1_val == MIN_NEG) && (rs2_val == '1);
    assign w_special  = w_div_zero || w_ovf;
    assign w_last     = (r_cnt == CW'(XLEN-1));

    assign w_mag1 = (w_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    assign w_mag2 = (w_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;

    // Special results are architectural constants, never sign-corrected.
    always_comb begin
        w_special_data = '0;
        if (w_div_zero) begin
            w_special_data = op[1] ? rs1_val : '1;
        end else begin
            w_special_data = op[1] ? '0 : MIN_NEG;
        end
    end

    assign w_trial   = {r_rem, r_dividend[XLEN-1]};
    assign w_ge      = (w_trial >= {1'b0, r_divisor});
    assign w_rem_nx  = w_ge ? (w_trial[XLEN-1:0] - r_divisor) : w_trial[XLEN-1:0];
    assign w_quot_nx = {r_quot[XLEN-2:0], w_ge};
    assign w_q_res   = r_neg_q ? -w_quot_nx : w_quot_nx;
    assign w_r_res   = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nx = (w_state_nx != S_IDLE);
        w_wen_nx  = 1'b0;
        w_addr_nx = w_addr;
        w_data_nx = w_data;
        if (r_state == S_IDLE && w_state_nx == S_DONE) begin
            w_wen_nx  = (rd_addr != 5'd0);
            w_addr_nx = rd_addr;
            w_data_nx = w_special_data;
        end else if (r_state == S_CALC && w_state_nx == S_DONE) begin
            w_wen_nx  = (r_rd != 5'd0);
            w_addr_nx = r_rd;
            w_data_nx = r_op_rem ? w_r_res : w_q_res;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy      <= 1'b0;
            w_enabled <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
        end else begin
            busy      <= w_busy_nx;
            w_enabled <= w_wen_nx;
            w_addr    <= w_addr_nx;
            w_data    <= w_data_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_op_rem   <= 1'b0;
            r_rd       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= w_mag1;
            r_divisor  <= w_mag2;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_op_rem   <= op[1];
            r_rd       <= rd_addr;
            r_neg_q    <= w_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
            r_neg_r    <= w_signed && rs1_val[XLEN-1];
        end else if (r_state == S_CALC && !flush) begin
            r_dividend <= {r_dividend[XLEN-2:0], 1'b0};
            r_rem      <= w_rem_nx;
            r_quot     <= w_quot_nx;
            r_cnt      <= r_cnt + CW'(1);
        end
    end

    assign dbg_state = r_state;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider for DIV, DIVU, REM and REMU.
- Sits in the execute stage, directly downstream of the register file.
- Consumes the registered rs1/rs2 operand values and drives results back into the register-file write port (w_enabled/w_addr/w_data).
- Multi-cycle, restoring, 1 quotient bit per cycle; asserts busy so the pipeline stalls while a division is in flight.

Parameters:
XLEN, 32, operand/result width; the only supported value is 32.

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_val  input  XLEN  dividend
rs2_val  input  XLEN  divisor
rd_addr  input  5  destination register
flush  input  1  abandon the in-flight operation (branch mispredict/trap)
busy  output  1  high from the cycle after an accepted start until DONE is left
w_enabled  output  1  one-cycle write strobe to the register file
w_addr  output  5  destination register for the write
w_data  output  XLEN  quotient or remainder

Behaviour:
- Reset: async on rstn low. State=IDLE; busy=0, w_enabled=0, w_addr=0, w_data=0; internal quotient/remainder/counter cleared. Takes effect mid-operation with no write.
- All outputs are registered. States: IDLE, CALC, DONE.
- IDLE, start=1 (flush=0), latch the following:
  - op and rd_addr.
  - Signedness: op[0]=0 is signed.
  - Operand magnitudes: absolute values for signed ops, raw values for unsigned.
  - Result signs: quotient negative = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1). Signed ops only.
- Special cases go IDLE -> DONE directly, with busy=1 for that one cycle:
  - Divisor 0: quotient = 0xFFFFFFFF; remainder = rs1_val.
  - Signed overflow (rs1_val=0x80000000, rs2_val=0xFFFFFFFF, op DIV/REM): quotient = 0x80000000; remainder = 0.
- Otherwise IDLE -> CALC with counter=0.
- CALC, one restoring step per cycle:
  - Form the trial value as the partial remainder shifted left by 1, with the next dividend MSB shifted in.
  - If trial >= divisor (unsigned 33-bit compare): partial remainder = trial - divisor, and shift 1 into the quotient.
  - Otherwise: partial remainder = trial, and shift 0 into the quotient.
  - counter increments each step. After step 31 (the 32nd step), go to DONE.
- Entering DONE:
  - w_data = quotient (op[1]=0) or remainder (op[1]=1), two's-complement negated if the corresponding latched sign is negative.
  - w_addr = latched rd.
  - w_enabled = 1 unless latched rd == 0. The register file does not guard x0, so this unit must.
- DONE lasts exactly 1 cycle, then IDLE with busy=0 and w_enabled=0. w_data/w_addr hold their last values.
- Latency, with start accepted at rising edge T:
  - Normal: busy high from T; w_enabled high during the cycle after edge T+32. That is 33 edges from start to result visible, and 34 cycles until a new start is accepted.
  - Special case: w_enabled high during the cycle after edge T. A new start is accepted at edge T+2.
- start while busy=1 (CALC or DONE): ignored, not queued.
- flush=1 in CALC: next state IDLE, no write, busy=0 next cycle.
- flush=1 in DONE: the write already presented still completes (the strobe is already registered); state returns to IDLE as normal.
- flush=1 and start=1 together in IDLE: start is ignored.
- The unit never reads the register file. Operands must be stable only at the accepting edge.

Test Plan:
- DIVU 100 / 7, rd=5: busy high 33 cycles; w_enabled 1 cycle with w_addr=5, w_data=14. REMU on the same operands -> w_data=2.
- DIV -7 / 2 (0xFFFFFFF9, 0x2): quotient 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). REM 7 / -2 -> 1.
- Divide by zero, DIV 0x1234 / 0, rd=3: w_enabled on the cycle after start with w_data=0xFFFFFFFF. REMU 0x1234 / 0 -> 0x1234. busy high exactly 1 cycle.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 cycle. REM of the same operands -> 0.
- rd=0 with DIVU 9 / 3: the full 33-cycle sequence runs, busy drops, w_enabled stays 0 throughout. start pulsed mid-CALC of a prior op is ignored: exactly one write occurs, with the first op's result.
- flush asserted at CALC step 10: no write, busy=0 next cycle, and a new DIVU 0xFFFFFFFF / 1 started immediately after returns 0xFFFFFFFF. Separately, rstn pulsed low mid-CALC clears all outputs asynchronously and produces no write.
